// File: rtl/check_node_ems_if.sv
`default_nettype none
// check_node_ems_if: A/I sorted-list input streams and the sorted output stream
// of the EMS check node. The master drives the lists in; the slave is the node.
interface check_node_ems_if #(
  parameter int LLR_W = 6,
  parameter int Q_W   = 6
);
  logic             a_valid;
  logic [LLR_W-1:0] a_llr;
  logic [Q_W-1:0]   a_sym;
  logic             a_ready;
  logic             i_valid;
  logic [LLR_W-1:0] i_llr;
  logic [Q_W-1:0]   i_sym;
  logic             i_ready;
  logic             out_valid;
  logic [LLR_W-1:0] out_llr;
  logic [Q_W-1:0]   out_sym;
  logic             out_last;
  logic             out_ready;

  modport master (
    output a_valid, a_llr, a_sym, input a_ready,
    output i_valid, i_llr, i_sym, input i_ready,
    input  out_valid, out_llr, out_sym, out_last, output out_ready
  );

  modport slave (
    input  a_valid, a_llr, a_sym, output a_ready,
    input  i_valid, i_llr, i_sym, output i_ready,
    output out_valid, out_llr, out_sym, out_last, input out_ready
  );
endinterface
`default_nettype wire

// File: rtl/check_node_ems.sv
`default_nettype none
// check_node_ems: elementary EMS check node; merges two LLR-sorted lists and emits
// the NOUT best unique-symbol combinations, padding with unseen symbols at LLR_MAX.
module check_node_ems #(
  parameter int LLR_W = 6,
  parameter int Q_W   = 6,
  parameter int NA    = 8,
  parameter int NI    = 8,
  parameter int NOUT  = 8,
  parameter int NSTEP = 16
) (
  input  logic              clk,
  input  logic              force_reset_n,
  input  logic              clr,
  check_node_ems_if.slave   bus,
  output logic              busy
);

  localparam int NSYM = 1 << Q_W;
  localparam int AC_W = $clog2(NA + 1);
  localparam int AX_W = $clog2(NA);
  localparam int PT_W = $clog2(NI + 1);
  localparam int IX_W = $clog2(NI);
  localparam int EM_W = $clog2(NOUT + 1);
  localparam int ST_W = $clog2(NSTEP + 1);
  localparam logic [LLR_W-1:0] LLR_MAX = '1;

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_FILL = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [AC_W-1:0]  a_cnt_q, a_cnt_d;
  logic [PT_W-1:0]  i_cnt_q, i_cnt_d;
  logic [EM_W-1:0]  emit_q, emit_d;
  logic [ST_W-1:0]  step_q, step_d;
  logic [NSYM-1:0]  seen_q, seen_d;
  logic [PT_W-1:0]  ptr_q [NA];
  logic [PT_W-1:0]  ptr_d [NA];

  logic [LLR_W-1:0] a_llr_q [NA];
  logic [Q_W-1:0]   a_sym_q [NA];
  logic [LLR_W-1:0] i_llr_q [NI];
  logic [Q_W-1:0]   i_sym_q [NI];
  logic [LLR_W-1:0] cand_llr_q [NA];
  logic [LLR_W-1:0] cand_llr_d [NA];
  logic [Q_W-1:0]   cand_sym_q [NA];
  logic [Q_W-1:0]   cand_sym_d [NA];

  logic             a_full, i_full, a_take, i_take;
  logic             sel_found, sel_seen, run_ok, advance;
  logic [AX_W-1:0]  sel_row;
  logic [LLR_W-1:0] sel_llr;
  logic [Q_W-1:0]   sel_sym;
  logic [Q_W-1:0]   fill_sym;
  logic [PT_W-1:0]  nxt;
  logic             last_word;

  function automatic logic [LLR_W-1:0] sat_add(input logic [LLR_W-1:0] x, input logic [LLR_W-1:0] y);
    logic [LLR_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[LLR_W] ? LLR_MAX : s[LLR_W-1:0];
  endfunction

  assign a_full    = (a_cnt_q == AC_W'(NA));
  assign i_full    = (i_cnt_q == PT_W'(NI));
  assign a_take    = bus.a_valid && bus.a_ready;
  assign i_take    = bus.i_valid && bus.i_ready;
  assign last_word = (emit_q == EM_W'(NOUT - 1));

  // Minimum-LLR live row; strict '<' keeps ties on the lowest row index.
  always_comb begin
    sel_found = 1'b0;
    sel_row   = '0;
    sel_llr   = '0;
    sel_sym   = '0;
    for (int r = 0; r < NA; r++) begin
      if (ptr_q[r] < PT_W'(NI) && (!sel_found || cand_llr_q[r] < sel_llr)) begin
        sel_found = 1'b1;
        sel_row   = AX_W'(r);
        sel_llr   = cand_llr_q[r];
        sel_sym   = cand_sym_q[r];
      end
    end
  end

  always_comb begin
    fill_sym = '0;
    for (int s = NSYM - 1; s >= 0; s--) begin
      if (!seen_q[s]) fill_sym = Q_W'(s);
    end
  end

  assign sel_seen = seen_q[sel_sym];
  assign run_ok   = sel_found && (step_q != ST_W'(NSTEP));

  // FSM: state register
  always_ff @(posedge clk or negedge force_reset_n) begin
    if (!force_reset_n)  state_q <= S_LOAD;
    else if (clr)        state_q <= S_LOAD;
    else                 state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD: if (a_full && i_full) state_d = S_INIT;
      S_INIT: state_d = S_RUN;
      S_RUN: begin
        if (!run_ok)                                  state_d = S_FILL;
        else if (!sel_seen && bus.out_ready && last_word) state_d = S_LOAD;
      end
      S_FILL: if (bus.out_ready && last_word) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  // FSM: outputs, from registered state only
  always_comb begin
    bus.a_ready   = (state_q == S_LOAD) && !a_full;
    bus.i_ready   = (state_q == S_LOAD) && !i_full;
    busy          = (state_q != S_LOAD);
    bus.out_valid = ((state_q == S_RUN) && run_ok && !sel_seen) || (state_q == S_FILL);
    bus.out_llr   = (state_q == S_FILL) ? LLR_MAX : sel_llr;
    bus.out_sym   = (state_q == S_FILL) ? fill_sym : sel_sym;
    bus.out_last  = bus.out_valid && last_word;
  end

  always_comb begin
    a_cnt_d    = a_cnt_q;
    i_cnt_d    = i_cnt_q;
    emit_d     = emit_q;
    step_d     = step_q;
    seen_d     = seen_q;
    ptr_d      = ptr_q;
    cand_llr_d = cand_llr_q;
    cand_sym_d = cand_sym_q;
    advance    = 1'b0;
    nxt        = ptr_q[sel_row] + PT_W'(1);
    case (state_q)
      S_LOAD: begin
        if (a_take) a_cnt_d = a_cnt_q + AC_W'(1);
        if (i_take) i_cnt_d = i_cnt_q + PT_W'(1);
      end
      S_INIT: begin
        for (int r = 0; r < NA; r++) begin
          cand_llr_d[r] = sat_add(a_llr_q[r], i_llr_q[0]);
          cand_sym_d[r] = a_sym_q[r] ^ i_sym_q[0];
          ptr_d[r]      = '0;
        end
      end
      S_RUN: begin
        // A duplicate is consumed without a handshake; a fresh symbol waits for out_ready.
        if (run_ok && (sel_seen || bus.out_ready)) begin
          advance = 1'b1;
          step_d  = step_q + ST_W'(1);
          if (!sel_seen) begin
            seen_d[sel_sym] = 1'b1;
            emit_d          = emit_q + EM_W'(1);
          end
        end
      end
      S_FILL: begin
        if (bus.out_ready) begin
          seen_d[fill_sym] = 1'b1;
          emit_d           = emit_q + EM_W'(1);
        end
      end
      default: ;
    endcase
    if (advance) begin
      ptr_d[sel_row] = nxt;
      if (nxt < PT_W'(NI)) begin
        cand_llr_d[sel_row] = sat_add(a_llr_q[sel_row], i_llr_q[nxt[IX_W-1:0]]);
        cand_sym_d[sel_row] = a_sym_q[sel_row] ^ i_sym_q[nxt[IX_W-1:0]];
      end
    end
    if (state_q != S_LOAD && state_d == S_LOAD) begin
      a_cnt_d = '0;
      i_cnt_d = '0;
      emit_d  = '0;
      step_d  = '0;
      seen_d  = '0;
      for (int r = 0; r < NA; r++) ptr_d[r] = '0;
    end
  end

  always_ff @(posedge clk or negedge force_reset_n) begin
    if (!force_reset_n) begin
      a_cnt_q <= '0;
      i_cnt_q <= '0;
      emit_q  <= '0;
      step_q  <= '0;
      seen_q  <= '0;
      ptr_q   <= '{default: '0};
    end else if (clr) begin
      a_cnt_q <= '0;
      i_cnt_q <= '0;
      emit_q  <= '0;
      step_q  <= '0;
      seen_q  <= '0;
      ptr_q   <= '{default: '0};
    end else begin
      a_cnt_q <= a_cnt_d;
      i_cnt_q <= i_cnt_d;
      emit_q  <= emit_d;
      step_q  <= step_d;
      seen_q  <= seen_d;
      ptr_q   <= ptr_d;
    end
  end

  // List storage and candidates carry no reset; they are rewritten before use.
  always_ff @(posedge clk) begin
    if (a_take) begin
      a_llr_q[a_cnt_q[AX_W-1:0]] <= bus.a_llr;
      a_sym_q[a_cnt_q[AX_W-1:0]] <= bus.a_sym;
    end
    if (i_take) begin
      i_llr_q[i_cnt_q[IX_W-1:0]] <= bus.i_llr;
      i_sym_q[i_cnt_q[IX_W-1:0]] <= bus.i_sym;
    end
    cand_llr_q <= cand_llr_d;
    cand_sym_q <= cand_sym_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_check_node_ems.sv
`default_nettype none
// tb_check_node_ems: directed and randomized list pairs checked against a sort-based
// reference of the EMS merge (global order by LLR, then row, then column).
module tb_check_node_ems;
  localparam int LLR_W   = 6;
  localparam int Q_W     = 2;
  localparam int NA      = 4;
  localparam int NI      = 4;
  localparam int NOUT    = 4;
  localparam int NSTEP   = 8;
  localparam int NSYM    = 1 << Q_W;
  localparam int LLR_MAX = (1 << LLR_W) - 1;

  logic clk = 1'b0;
  logic force_reset_n;
  logic clr;
  logic busy;

  check_node_ems_if #(.LLR_W(LLR_W), .Q_W(Q_W)) bus ();

  check_node_ems #(
    .LLR_W(LLR_W), .Q_W(Q_W), .NA(NA), .NI(NI), .NOUT(NOUT), .NSTEP(NSTEP)
  ) dut (
    .clk          (clk),
    .force_reset_n(force_reset_n),
    .clr          (clr),
    .bus          (bus),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int la[NA], sa[NA], li[NI], si[NI];
  int el[NOUT], es[NOUT];

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Row heads are merged in (llr,row,col) order, so a full sort reproduces the evaluation order.
  task automatic model();
    int keys[NA*NI];
    bit seen[NSYM];
    int n, t, idx, r, c, sym, s;
    n = 0;
    for (int k = 0; k < NSYM; k++) seen[k] = 1'b0;
    for (int rr = 0; rr < NA; rr++)
      for (int cc = 0; cc < NI; cc++) begin
        s = la[rr] + li[cc];
        if (s > LLR_MAX) s = LLR_MAX;
        keys[rr*NI+cc] = s * 1024 + rr * NI + cc;
      end
    for (int i = 1; i < NA*NI; i++)
      for (int j = i; j > 0; j--) begin
        if (keys[j-1] > keys[j]) begin
          t = keys[j]; keys[j] = keys[j-1]; keys[j-1] = t;
        end else break;
      end
    for (int k = 0; k < NSTEP && k < NA*NI && n < NOUT; k++) begin
      idx = keys[k] % 1024;
      r = idx / NI;
      c = idx % NI;
      sym = sa[r] ^ si[c];
      if (!seen[sym]) begin
        seen[sym] = 1'b1; el[n] = keys[k] / 1024; es[n] = sym; n++;
      end
    end
    for (int q = 0; q < NSYM && n < NOUT; q++)
      if (!seen[q]) begin
        seen[q] = 1'b1; el[n] = LLR_MAX; es[n] = q; n++;
      end
  endtask

  task automatic rand_lists();
    int v;
    v = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : $urandom_range(0, 8);
    for (int k = 0; k < NA; k++) begin
      la[k] = v; sa[k] = $urandom_range(0, NSYM-1);
      v += $urandom_range(0, 12); if (v > LLR_MAX) v = LLR_MAX;
    end
    v = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : $urandom_range(0, 8);
    for (int k = 0; k < NI; k++) begin
      li[k] = v; si[k] = $urandom_range(0, NSYM-1);
      v += $urandom_range(0, 12); if (v > LLR_MAX) v = LLR_MAX;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the edge that completes loading.
  task automatic load_lists();
    int ai, ii, cyc;
    bit av, iv, ar, ir;
    ai = 0; ii = 0; cyc = 0;
    while ((ai < NA || ii < NI) && cyc < 200) begin
      av = (ai < NA) && ($urandom_range(0, 3) != 0);
      iv = (ii < NI) && ($urandom_range(0, 3) != 0);
      bus.a_valid = av;
      bus.i_valid = iv;
      if (ai < NA) begin bus.a_llr = LLR_W'(la[ai]); bus.a_sym = Q_W'(sa[ai]); end
      if (ii < NI) begin bus.i_llr = LLR_W'(li[ii]); bus.i_sym = Q_W'(si[ii]); end
      ar = bus.a_ready;
      ir = bus.i_ready;
      @(posedge clk); #1; cyc++;
      if (av && ar) ai++;
      if (iv && ir) ii++;
    end
    bus.a_valid = 1'b0;
    bus.i_valid = 1'b0;
    if (ai < NA || ii < NI) chk("load_timeout", ai + ii, NA + NI);
  endtask

  // Garbage is offered on A/I throughout; it must be ignored while the node is busy.
  task automatic collect(input string tag, input int rdy_pct, input bit stall_first);
    int got, cyc, hl, hs, hv;
    bit rdy, stalled, pv, pr;
    got = 0; cyc = 0; stalled = 1'b0; pv = 1'b0; pr = 1'b0; hl = 0; hs = 0; hv = 0;
    while (got < NOUT && cyc < 400) begin
      bus.a_valid = 1'b1; bus.a_llr = LLR_W'($urandom); bus.a_sym = Q_W'($urandom);
      bus.i_valid = 1'b1; bus.i_llr = LLR_W'($urandom); bus.i_sym = Q_W'($urandom);
      if (pv && !pr) begin
        chk({tag, "_hold_v"}, int'(bus.out_valid), 1);
        chk({tag, "_hold_llr"}, int'(bus.out_llr), hl);
        chk({tag, "_hold_sym"}, int'(bus.out_sym), hs);
      end
      if (stall_first && !stalled && bus.out_valid) begin
        stalled = 1'b1;
        hl = int'(bus.out_llr); hs = int'(bus.out_sym);
        bus.out_ready = 1'b0;
        repeat (5) begin
          @(posedge clk); #1; cyc++;
          chk({tag, "_stall_v"}, int'(bus.out_valid), 1);
          chk({tag, "_stall_llr"}, int'(bus.out_llr), hl);
          chk({tag, "_stall_sym"}, int'(bus.out_sym), hs);
        end
      end
      rdy = ($urandom_range(1, 100) <= rdy_pct);
      bus.out_ready = rdy;
      pv = bus.out_valid; pr = rdy;
      hl = int'(bus.out_llr); hs = int'(bus.out_sym); hv = int'(bus.out_last);
      if (bus.out_valid && rdy) begin
        chk({tag, "_llr"}, int'(bus.out_llr), el[got]);
        chk({tag, "_sym"}, int'(bus.out_sym), es[got]);
        chk({tag, "_last"}, hv, (got == NOUT - 1) ? 1 : 0);
        got++;
      end
      @(posedge clk); #1; cyc++;
    end
    bus.out_ready = 1'b0;
    bus.a_valid   = 1'b0;
    bus.i_valid   = 1'b0;
    if (got < NOUT) chk({tag, "_timeout"}, got, NOUT);
    chk({tag, "_done_rdy"}, int'({bus.a_ready, bus.i_ready, busy, bus.out_valid}), 4'b1100);
  endtask

  task automatic run_one(input string tag, input int rdy_pct, input bit stall_first);
    model();
    load_lists();
    collect(tag, rdy_pct, stall_first);
  endtask

  task automatic to_run();
    load_lists();
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic normal_lists();
    la = '{0, 2, 5, 9};  sa = '{1, 2, 3, 0};
    li = '{0, 1, 4, 7};  si = '{0, 1, 2, 3};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    force_reset_n = 1'b0;
    clr = 1'b0;
    bus.a_valid = 1'b0; bus.a_llr = '0; bus.a_sym = '0;
    bus.i_valid = 1'b0; bus.i_llr = '0; bus.i_sym = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_a_ready", int'(bus.a_ready), 1);
    chk("rst_i_ready", int'(bus.i_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1 force_reset_n = 1'b1;

    // Normal run with first-output latency
    normal_lists();
    model();
    chk("normal_model0", el[0] * 16 + es[0], 0 * 16 + 1);
    load_lists();
    chk("lat_load", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    chk("lat_init_v", int'(bus.out_valid), 0);
    chk("lat_init_busy", int'(busy), 1);
    @(posedge clk); #1;
    chk("lat_run_v", int'(bus.out_valid), 1);
    collect("normal", 100, 1'b0);

    // Duplicates then fill
    la = '{0, 1, 2, 3};  sa = '{0, 0, 0, 0};
    li = '{0, 4, 8, 12}; si = '{0, 1, 2, 3};
    run_one("dupfill", 100, 1'b0);

    // Saturation
    la = '{40, 41, 42, 43}; sa = '{0, 1, 2, 3};
    li = '{30, 31, 32, 33}; si = '{0, 0, 0, 0};
    run_one("sat", 100, 1'b0);

    // Stall on first word
    normal_lists();
    run_one("stall", 100, 1'b1);

    // Tie-break on equal LLRs
    la = '{0, 0, 0, 0};  sa = '{3, 2, 1, 0};
    li = '{0, 5, 6, 7};  si = '{0, 0, 0, 0};
    run_one("tie", 100, 1'b0);

    // Async reset mid-RUN
    normal_lists();
    to_run();
    chk("rst_pre_v", int'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    #2 force_reset_n = 1'b0;
    #1;
    chk("rst_mid_v", int'(bus.out_valid), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_ardy", int'(bus.a_ready), 1);
    @(posedge clk); #1 force_reset_n = 1'b1;
    rand_lists();
    run_one("post_rst", 70, 1'b0);

    // Synchronous clear mid-RUN
    normal_lists();
    to_run();
    chk("clr_pre_v", int'(bus.out_valid), 1);
    clr = 1'b1;
    #2;
    chk("clr_hold_v", int'(bus.out_valid), 1);
    @(posedge clk); #1;
    chk("clr_v", int'(bus.out_valid), 0);
    chk("clr_busy", int'(busy), 0);
    clr = 1'b0;
    rand_lists();
    run_one("post_clr", 70, 1'b0);

    // Randomized lists and backpressure
    for (int t = 0; t < 30; t++) begin
      rand_lists();
      run_one("rand", $urandom_range(40, 100), t[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
